// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - instruction memory request/response bus
interface instruction_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - fetch stage with IF/ID register, freeze hold buffer and branch drain
module instruction_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_addr,
    instruction_fetch_stage_if.master imem,
    output logic                      if_valid,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_instr
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] target, target_next;
    logic [31:0] buf_instr, buf_instr_next;
    logic [31:0] buf_pc, buf_pc_next;
    logic        if_valid_next;
    logic [31:0] if_pc_next, if_instr_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Outputs come only from registers (plus reset gating) so decode sees no input-to-output path.
    assign imem.imem_req  = !rst && (state != HOLD);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            target    <= 32'd0;
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
            if_valid  <= 1'b0;
            if_pc     <= 32'd0;
            if_instr  <= 32'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            target    <= target_next;
            buf_instr <= buf_instr_next;
            buf_pc    <= buf_pc_next;
            if_valid  <= if_valid_next;
            if_pc     <= if_pc_next;
            if_instr  <= if_instr_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        target_next    = target;
        buf_instr_next = buf_instr;
        buf_pc_next    = buf_pc;
        if_valid_next  = if_valid;
        if_pc_next     = if_pc;
        if_instr_next  = if_instr;

        case (state)
            FETCH: begin
                if (imem.imem_ready) begin
                    if (branch_taken) begin
                        pc_next       = branch_addr;
                        if_valid_next = 1'b0;
                    end else if (freeze) begin
                        // Word arrived while decode is stalled: park it instead of losing it.
                        buf_instr_next = imem.imem_rdata;
                        buf_pc_next    = pc_plus4;
                        pc_next        = pc_plus4;
                        state_next     = HOLD;
                    end else begin
                        if_valid_next = 1'b1;
                        if_pc_next    = pc_plus4;
                        if_instr_next = imem.imem_rdata;
                        pc_next       = pc_plus4;
                    end
                end else begin
                    if (branch_taken) begin
                        // Request cannot be withdrawn; remember the target until it completes.
                        target_next   = branch_addr;
                        if_valid_next = 1'b0;
                        state_next    = DRAIN;
                    end else if (!freeze) begin
                        if_valid_next = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_next        = branch_addr;
                    if_valid_next  = 1'b0;
                    buf_instr_next = 32'd0;
                    buf_pc_next    = 32'd0;
                    state_next     = FETCH;
                end else if (!freeze) begin
                    if_valid_next = 1'b1;
                    if_pc_next    = buf_pc;
                    if_instr_next = buf_instr;
                    state_next    = FETCH;
                end
            end
            DRAIN: begin
                if_valid_next = 1'b0;
                if (branch_taken) begin
                    target_next = branch_addr;
                end
                if (imem.imem_ready) begin
                    pc_next    = branch_taken ? branch_addr : target;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next    = FETCH;
                if_valid_next = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench with variable-latency memory and program-order model
module tb_instruction_fetch_stage;
    localparam logic [31:0] PC_RST = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    instruction_fetch_stage_if imem ();

    instruction_fetch_stage #(.PC_RESET(PC_RST)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_consumed = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_next = PC_RST;

    int          lat_min = 0;
    int          lat_max = 0;
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Program-order model: after any redirect, decode must consume target, target+4, ...
    task automatic model_redirect(input logic [31:0] a);
        exp_q.delete();
        exp_next = a;
    endtask

    task automatic model_topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc     = exp_next + 32'd4;
            e.instr  = mem_word(exp_next);
            exp_q.push_back(e);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic mem_step();
        logic [31:0] junk;
        junk = $urandom();
        if (rst || !imem.imem_req) begin
            imem.imem_ready = 1'b0;
            imem.imem_rdata = junk;
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = int'($urandom_range(lat_max, lat_min));
                mem_addr = imem.imem_addr;
            end
            if (mem_wait == 0) begin
                imem.imem_ready = 1'b1;
                imem.imem_rdata = mem_word(mem_addr);
                mem_busy = 1'b0;
            end else begin
                imem.imem_ready = 1'b0;
                imem.imem_rdata = junk;
                mem_wait--;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] ba);
        @(negedge clk);
        rst = r;
        freeze = f;
        branch_taken = b;
        branch_addr = ba;
        if (r) model_redirect(PC_RST);
        else if (b) model_redirect(ba);
        #1;
        mem_step();
        model_topup();
    endtask

    // Monitor: protocol, reset and scoreboard checks, sampled mid-cycle.
    logic        rst_q = 1'b1;
    logic        hs_pending = 1'b0;
    logic [31:0] hs_addr = 32'd0;

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst_q) begin
            chk("rst_if_valid", 32'(if_valid), 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_instr", if_instr, 32'd0);
            chk("rst_imem_addr", imem.imem_addr, PC_RST);
        end
        if (rst) begin
            chk("rst_imem_req", 32'(imem.imem_req), 32'd0);
        end else if (hs_pending) begin
            chk("hs_req_held", 32'(imem.imem_req), 32'd1);
            chk("hs_addr_stable", imem.imem_addr, hs_addr);
        end
        if (!rst && if_valid === 1'b1) n_valid++;
        if (!rst && if_valid === 1'b1 && !freeze && !branch_taken) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_empty: consumed pc %h with no expected entry", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
            end
        end
        hs_pending = !rst && imem.imem_req && !imem.imem_ready;
        hs_addr    = imem.imem_addr;
        rst_q      = rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic        r, f, b, found;
    logic [31:0] ba, tmp;
    int          n_start;

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'd0;

        // Zero-wait memory, no stalls: one instruction per cycle.
        lat_min = 0; lat_max = 0;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        n_valid = 0;
        cyc(0, 0, 0, 0); #1; chk("first_addr0", imem.imem_addr, 32'h0);
        cyc(0, 0, 0, 0); #1; chk("first_addr4", imem.imem_addr, 32'h4);
        chk("first_pc", if_pc, 32'h4); chk("first_instr", if_instr, mem_word(32'h0));
        cyc(0, 0, 0, 0); #1; chk("first_addr8", imem.imem_addr, 32'h8);
        repeat (27) cyc(0, 0, 0, 0);
        #5; chk("zero_wait_rate", 32'(n_valid), 32'd29);

        // Two wait states: one valid cycle in every three.
        lat_min = 2; lat_max = 2;
        cyc(1, 0, 0, 0);
        n_valid = 0;
        repeat (30) cyc(0, 0, 0, 0);
        #5; chk("wait2_rate", 32'(n_valid), 32'd9);

        // Freeze while the word at 0x10 returns, then release.
        lat_min = 0; lat_max = 0;
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0); #1; chk("frz_addr", imem.imem_addr, 32'h10);
        cyc(0, 1, 0, 0); #1; chk("hold_req", 32'(imem.imem_req), 32'd0); chk("hold_if_pc", if_pc, 32'h10);
        cyc(0, 1, 0, 0); #1; chk("hold_req2", 32'(imem.imem_req), 32'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0); #1;
        chk("rel_valid", 32'(if_valid), 32'd1);
        chk("rel_pc", if_pc, 32'h14);
        chk("rel_instr", if_instr, mem_word(32'h10));

        // Branch with nothing outstanding.
        cyc(0, 0, 1, 32'h100);
        cyc(0, 0, 0, 0); #1; chk("br_flush", 32'(if_valid), 32'd0); chk("br_addr", imem.imem_addr, 32'h100);
        cyc(0, 0, 0, 0); #1; chk("br_valid", 32'(if_valid), 32'd1); chk("br_pc", if_pc, 32'h104);

        // Freeze and branch together in HOLD: branch wins.
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h300); #1; chk("hb_req", 32'(imem.imem_req), 32'd0);
        cyc(0, 0, 0, 0); #1; chk("hb_addr", imem.imem_addr, 32'h300); chk("hb_flush", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 0); #1; chk("hb_pc", if_pc, 32'h304);

        // PC wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFF8);
        repeat (6) cyc(0, 0, 0, 0);

        // Branch during a wait on 0x20: drain, then redirect.
        lat_min = 2; lat_max = 2;
        cyc(1, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(0, 0, 0, 0); #1;
            if (imem.imem_addr == 32'h20) found = 1'b1;
        end
        chk("drain_reach", 32'(found), 32'd1);
        cyc(0, 0, 1, 32'h200);
        cyc(0, 0, 0, 0); #1; chk("drain_addr", imem.imem_addr, 32'h20); chk("drain_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 0); #1; chk("drain_redir", imem.imem_addr, 32'h200);
        repeat (8) cyc(0, 0, 0, 0);

        // Reset asserted while draining.
        lat_min = 3; lat_max = 3;
        cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h400);
        cyc(1, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);

        // Randomized traffic.
        lat_min = 0; lat_max = 3;
        cyc(1, 0, 0, 0);
        n_start = n_consumed;
        repeat (3000) begin
            r = ($urandom_range(99) == 0);
            f = ($urandom_range(3) == 0);
            b = ($urandom_range(15) == 0);
            tmp = $urandom();
            if ($urandom_range(7) == 0) ba = 32'hFFFF_FFF0 + {tmp[1:0], 2'b00};
            else ba = {tmp[31:2], 2'b00};
            cyc(r, f, b, ba);
        end
        #5; chk("rand_progress", 32'(n_consumed - n_start > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
